mem_controller: RTL and testbench
=================================

Name: mem_controller

Overview:
- Responder end of the pipeline memory-controller interface.
- Accepts 32-bit word read/write requests from the Memory stage and splits each into two 16-bit accesses on an external asynchronous SRAM (256K x 16).
- Stalls the pipeline until each request completes.

Parameters:
- WAIT_STATES, 0, extra cycles each SRAM half-access is held; each half lasts WAIT_STATES+1 cycles.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mem_mc_rw  input  1  1 = write, 0 = read; valid when mem_mc_en=1
- mem_mc_en  input  1  request valid; held stable by the pipeline while mc_stall=1
- mem_mc_addr  input  18  word address; bit 17 ignored (128K words)
- mem_mc_data  inout  32  write data from the stage; read data driven by this block
- mc_stall  output  1  hold the pipeline
- sram_addr  output  18  SRAM halfword address
- sram_data  inout  16  SRAM data bus
- sram_ce_n  output  1  SRAM chip enable, active-low
- sram_oe_n  output  1  SRAM output enable, active-low
- sram_we_n  output  1  SRAM write enable, active-low
- sram_ub_n  output  1  SRAM upper-byte enable, active-low
- sram_lb_n  output  1  SRAM lower-byte enable, active-low

Behaviour:
- Clock domain: clock only. reset is synchronous, active-high.
- Reset (takes priority in any state, including mid-access):
  - state=IDLE, wait counter=0, read/write data regs=0.
  - sram_addr=0; ce_n/oe_n/we_n/ub_n/lb_n=1.
  - sram_data and mem_mc_data tri-stated.
  - mc_stall=0 while reset=1.
- mc_stall (combinational) = mem_mc_en & (state!=DONE) & !reset.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE, en=1: latch rw, addr, and mem_mc_data (if write) -> LO.
    - Registered SRAM outputs: sram_addr={addr[16:0],1'b0}, ce_n=0, ub_n=0, lb_n=0; oe_n=0 for read, we_n=0 for write.
  - LO:
    - Hold for WAIT_STATES+1 cycles (counter).
    - On the last cycle: read captures sram_data into rd[15:0]. Then sram_addr[0]=1 -> HI.
  - HI:
    - Same timing as LO. Read captures rd[31:16].
    - On exit: ce_n/oe_n/we_n/ub_n/lb_n=1 -> DONE.
  - DONE: mc_stall=0, so the stage advances this cycle.
    - Read: drive mem_mc_data=rd for this cycle only.
    - Always -> IDLE.
- Latency: request seen in IDLE at cycle 0. mc_stall high for 1+2*(WAIT_STATES+1) cycles; DONE follows. WAIT_STATES=0 gives 3 stall cycles, result in cycle 3.
- Back-to-back requests: one IDLE cycle between DONE and the next LO.
- sram_data drive:
  - Driven only in a write LO (wr[15:0]) or write HI (wr[31:16]); otherwise Z.
  - Never driven while oe_n=0.
- mem_mc_data drive: driven only in DONE of a read (rw=0). Never driven when rw=1, so there is no contention with the stage's write driver.
- Abort: en drops in LO or HI -> all SRAM strobes deasserted next edge, -> IDLE. No data returned. A write may be partially done.
- rw or addr changing mid-request is illegal. The latched values are used.

Optional Feature:
- Macro: MC_READ_BUFFER_EN.
- Defined: one-entry read buffer (valid, addr[16:0], data).
  - Read hit in IDLE (valid & addr match) -> DONE directly; 1 stall cycle, no SRAM activity.
  - Completed read miss fills the buffer.
  - Completed write to the buffered address updates the buffer data.
  - Aborted write to the buffered address clears valid.
  - Reset clears valid.
- Undefined: no buffer; every read takes the full SRAM sequence.

Test Plan:
- Reset mid-read (in HI) -> next cycle state IDLE, all strobes 1, mc_stall=0 while reset=1, both buses Z.
- Write addr 0x00005, data 0xDEADBEEF, WAIT_STATES=0:
  - sram_addr 0x0000A with sram_data 0xBEEF, then 0x0000B with 0xDEAD, we_n low for 2 cycles.
  - mc_stall high exactly 3 cycles.
- Read addr 0x00005 with SRAM model holding the above -> mem_mc_data=0xDEADBEEF in the DONE cycle only; Z before and after.
- WAIT_STATES=2, read -> each half held 3 cycles, mc_stall high 7 cycles, data correct.
- Read aborted (en=0 during LO) -> strobes released next edge, no mem_mc_data drive, following write completes normally.
- MC_READ_BUFFER_EN:
  - Read 0x00100 twice -> second read stalls 1 cycle, no ce_n activity.
  - Write 0x12345678 to 0x00100, then read -> 0x12345678 with 1 stall cycle.

Source files
------------

// File: rtl/mem_controller.sv
// mem_controller: 32-bit pipeline requests served as two 16-bit async SRAM accesses.
// Define MC_READ_BUFFER_EN for a one-entry read buffer that answers repeat reads.
module mem_controller #(
    parameter int WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_mc_rw,
    input  logic        mem_mc_en,
    input  logic [17:0] mem_mc_addr,
    inout  wire  [31:0] mem_mc_data,
    output logic        mc_stall,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rw_q;
    logic [16:0]   addr_q;
    logic [31:0]   wr_q;
    logic [31:0]   rd_q;
    logic          last;
    logic          unused_addr_msb;

    // Only 128K words are populated, so the top address bit is dropped.
    assign unused_addr_msb = mem_mc_addr[17];

    assign last     = (cnt == CNT_LAST);
    assign mc_stall = mem_mc_en & (state != DONE) & ~reset;

    assign sram_data = (rw_q && state == LO) ? wr_q[15:0]  :
                       (rw_q && state == HI) ? wr_q[31:16] : 16'hzzzz;

    assign mem_mc_data = (!rw_q && state == DONE) ? rd_q : 32'hzzzz_zzzz;

`ifdef MC_READ_BUFFER_EN
    logic        buf_valid;
    logic [16:0] buf_addr;
    logic [31:0] buf_data;
    logic        hit;

    assign hit = buf_valid && !mem_mc_rw && (buf_addr == mem_mc_addr[16:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (state == HI && last && mem_mc_en) begin
            if (!rw_q) begin
                buf_valid <= 1'b1;
                buf_addr  <= addr_q;
                buf_data  <= {sram_data, rd_q[15:0]};
            end else if (buf_addr == addr_q) begin
                buf_data <= wr_q;
            end
        end else if ((state == LO || state == HI) && !mem_mc_en
                     && rw_q && buf_addr == addr_q) begin
            // A half-finished write leaves the SRAM word unknown.
            buf_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mem_mc_en) begin
                        rw_q   <= mem_mc_rw;
                        addr_q <= mem_mc_addr[16:0];
                        if (mem_mc_rw) wr_q <= mem_mc_data;
`ifdef MC_READ_BUFFER_EN
                        if (hit) begin
                            rd_q  <= buf_data;
                            state <= DONE;
                        end else
`endif
                        begin
                            sram_addr <= {mem_mc_addr[16:0], 1'b0};
                            sram_ce_n <= 1'b0;
                            sram_ub_n <= 1'b0;
                            sram_lb_n <= 1'b0;
                            sram_oe_n <= mem_mc_rw;
                            sram_we_n <= ~mem_mc_rw;
                            state     <= LO;
                        end
                    end
                end
                LO, HI: begin
                    if (!mem_mc_en) begin
                        cnt       <= '0;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        state     <= IDLE;
                    end else if (!last) begin
                        cnt <= cnt + 1'b1;
                    end else if (state == LO) begin
                        cnt <= '0;
                        if (!rw_q) rd_q[15:0] <= sram_data;
                        sram_addr[0] <= 1'b1;
                        state        <= HI;
                    end else begin
                        cnt <= '0;
                        if (!rw_q) rd_q[31:16] <= sram_data;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: two DUTs (WAIT_STATES 0 and 2) against a word-level memory model.
// Build with MC_READ_BUFFER_EN defined to cover the read-buffer hit path.
module tb_mem_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rw = 1'b0;
    logic        en0 = 1'b0, en1 = 1'b0;
    logic        drv0 = 1'b0, drv1 = 1'b0;
    logic [17:0] addr = '0;
    logic [31:0] wdata = '0;

    wire  [31:0] bus0, bus1;
    wire  [15:0] sd0, sd1;
    logic        st0, st1;
    logic [17:0] sa0, sa1;
    logic        ce0, oe0, we0, ub0, lb0;
    logic        ce1, oe1, we1, ub1, lb1;
    logic        bz0, bz1, sdz0, sdz1;

    int cmp_n = 0;
    int fail_n = 0;

    always #5 clock = ~clock;

    assign bus0 = drv0 ? wdata : 32'hzzzz_zzzz;
    assign bus1 = drv1 ? wdata : 32'hzzzz_zzzz;
    assign bz0  = (bus0 === 32'hzzzz_zzzz);
    assign bz1  = (bus1 === 32'hzzzz_zzzz);
    assign sdz0 = (sd0 === 16'hzzzz);
    assign sdz1 = (sd1 === 16'hzzzz);

    mem_controller #(.WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .mem_mc_rw(rw), .mem_mc_en(en0),
        .mem_mc_addr(addr), .mem_mc_data(bus0), .mc_stall(st0),
        .sram_addr(sa0), .sram_data(sd0), .sram_ce_n(ce0), .sram_oe_n(oe0),
        .sram_we_n(we0), .sram_ub_n(ub0), .sram_lb_n(lb0)
    );

    mem_controller #(.WAIT_STATES(2)) dut1 (
        .clock(clock), .reset(reset), .mem_mc_rw(rw), .mem_mc_en(en1),
        .mem_mc_addr(addr), .mem_mc_data(bus1), .mc_stall(st1),
        .sram_addr(sa1), .sram_data(sd1), .sram_ce_n(ce1), .sram_oe_n(oe1),
        .sram_we_n(we1), .sram_ub_n(ub1), .sram_lb_n(lb1)
    );

    // Async SRAM models, one per DUT.
    logic [15:0] sm0 [0:262143];
    logic [15:0] sm1 [0:262143];
    assign sd0 = (!ce0 && !oe0 && we0) ? sm0[sa0] : 16'hzzzz;
    assign sd1 = (!ce1 && !oe1 && we1) ? sm1[sa1] : 16'hzzzz;
    always @(posedge clock) if (!ce0 && !we0) sm0[sa0] <= sd0;
    always @(posedge clock) if (!ce1 && !we1) sm1[sa1] <= sd1;

    // Word-level reference: memory contents and read-buffer occupancy.
    logic [31:0] refm [bit [17:0]];
    bit          bv [2];
    logic [16:0] ba [2];
    logic [16:0] pool [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] refget(input bit s, input logic [16:0] a);
        if (refm.exists({s, a})) return refm[{s, a}];
        return 32'h0;
    endfunction

    function automatic logic stall_of(input bit s);
        return s ? st1 : st0;
    endfunction

    function automatic logic busz_of(input bit s);
        return s ? bz1 : bz0;
    endfunction

    function automatic logic sdz_of(input bit s);
        return s ? sdz1 : sdz0;
    endfunction

    function automatic logic [31:0] bus_of(input bit s);
        return s ? bus1 : bus0;
    endfunction

    function automatic logic [15:0] sd_of(input bit s);
        return s ? sd1 : sd0;
    endfunction

    function automatic logic [4:0] strobes_of(input bit s);
        return s ? {ce1, oe1, we1, ub1, lb1} : {ce0, oe0, we0, ub0, lb0};
    endfunction

    function automatic logic [22:0] sram_of(input bit s);
        return s ? {sa1, ce1, oe1, we1, ub1, lb1} : {sa0, ce0, oe0, we0, ub0, lb0};
    endfunction

    task automatic drive_idle();
        en0 = 1'b0; en1 = 1'b0; drv0 = 1'b0; drv1 = 1'b0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        for (int i = 0; i < n; i++) begin
            #1;
            chk("idle_stall0", st0, 1'b0);
            chk("idle_stall1", st1, 1'b0);
            chk("idle_bus_z0", bz0, 1'b1);
            chk("idle_bus_z1", bz1, 1'b1);
            @(negedge clock);
        end
    endtask

    // Called at a negedge; returns at a negedge. abort_k: 0 none, -1 random, else that cycle.
    task automatic xact(input bit s, input bit w, input logic [17:0] a,
                        input logic [31:0] d, input int abort_k,
                        output int nst, output logic [31:0] rdv, output bit aborted);
        int ws, n, ak, h;
        bit hit;
        logic [31:0] exp;
        logic [22:0] esr;
        ws = s ? 2 : 0;
        hit = 1'b0;
`ifdef MC_READ_BUFFER_EN
        hit = !w && bv[s] && (ba[s] == a[16:0]);
`endif
        n = hit ? 1 : 1 + 2 * (ws + 1);
        exp = refget(s, a[16:0]);
        ak = abort_k;
        if (ak < 0) ak = (n > 1) ? $urandom_range(n - 1, 1) : 0;
        if (ak >= n) ak = 0;
        rw = w; addr = a; wdata = d;
        en0 = !s; en1 = s;
        drv0 = w && !s; drv1 = w && s;
        nst = 0; rdv = '0; aborted = 1'b0;
        for (int k = 0; k <= n; k++) begin
            #1;
            chk("stall", stall_of(s), k < n);
            if (stall_of(s)) nst++;
            if (k == 0 || k == n) begin
                chk("strobes_off", strobes_of(s), 5'h1f);
            end else begin
                h = (k - 1) / (ws + 1);
                esr = {a[16:0], h[0], 1'b0, w, !w, 1'b0, 1'b0};
                chk("sram_ctl", sram_of(s), esr);
                if (w) chk("sram_wdata", sd_of(s), h[0] ? d[31:16] : d[15:0]);
            end
            if (!w) begin
                if (k == n) begin
                    rdv = bus_of(s);
                    chk("rd_data", rdv, exp);
                end else begin
                    chk("bus_z", busz_of(s), 1'b1);
                end
            end
            if (k == ak && ak > 0) begin
                drive_idle();
                #1;
                chk("abort_stall", stall_of(s), 1'b0);
                @(negedge clock);
                #1;
                chk("abort_strobes", strobes_of(s), 5'h1f);
                chk("abort_bus_z", busz_of(s), 1'b1);
                chk("abort_sram_z", sdz_of(s), 1'b1);
                if (w && bv[s] && ba[s] == a[16:0]) bv[s] = 1'b0;
                aborted = 1'b1;
                @(negedge clock);
                break;
            end
            @(negedge clock);
        end
        if (!aborted) begin
            if (w) refm[{s, a[16:0]}] = d;
            else if (!hit) begin
                bv[s] = 1'b1;
                ba[s] = a[16:0];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nst;
        logic [31:0] rdv;
        bit ab;
        bit s, w;
        logic [17:0] a;
        logic [31:0] d;

        bv[0] = 1'b0; bv[1] = 1'b0; ba[0] = '0; ba[1] = '0;
        pool[0] = 17'h00005;
        pool[1] = 17'h00100;
        for (int i = 2; i < 16; i++) pool[i] = 17'($urandom);

        // Reset state, with a request pending that must not stall.
        @(negedge clock);
        @(negedge clock);
        en0 = 1'b1; en1 = 1'b1; rw = 1'b0;
        #1;
        chk("reset_stall0", st0, 1'b0);
        chk("reset_stall1", st1, 1'b0);
        @(negedge clock);
        #1;
        chk("reset_strobes0", strobes_of(1'b0), 5'h1f);
        chk("reset_addr0", sa0, 18'h0);
        chk("reset_bus_z0", bz0, 1'b1);
        chk("reset_sram_z0", sdz0, 1'b1);
        drive_idle();
        reset = 1'b0;
        @(negedge clock);
        idle(2);

        // Directed write then read-back at zero wait states.
        xact(1'b0, 1'b1, 18'h00005, 32'hDEADBEEF, 0, nst, rdv, ab);
        chk("wr_stall_cycles", nst, 3);
        chk("sram_lo_word", sm0[18'h0000A], 16'hBEEF);
        chk("sram_hi_word", sm0[18'h0000B], 16'hDEAD);
        idle(1);
        xact(1'b0, 1'b0, 18'h20005, 32'h0, 0, nst, rdv, ab);
        chk("rd_stall_cycles", nst, 3);
        chk("rd_value", rdv, 32'hDEADBEEF);
        idle(1);

        // Two wait states.
        xact(1'b1, 1'b1, 18'h00005, 32'hCAFEF00D, 0, nst, rdv, ab);
        chk("ws2_wr_stall", nst, 7);
        xact(1'b1, 1'b0, 18'h00005, 32'h0, 0, nst, rdv, ab);
        chk("ws2_rd_stall", nst, 7);
        chk("ws2_rd_value", rdv, 32'hCAFEF00D);
        idle(1);

        // Read aborted in LO, then a write that completes, then read back.
        xact(1'b0, 1'b0, 18'h00009, 32'h0, 1, nst, rdv, ab);
        chk("abort_taken", ab, 1'b1);
        xact(1'b0, 1'b1, 18'h00007, 32'hABCD1234, 0, nst, rdv, ab);
        chk("post_abort_wr_stall", nst, 3);
        xact(1'b0, 1'b0, 18'h00007, 32'h0, 0, nst, rdv, ab);
        chk("post_abort_rd", rdv, 32'hABCD1234);
        // Write aborted in HI on the slow port, then rewritten.
        xact(1'b1, 1'b1, 18'h00007, 32'h11112222, 4, nst, rdv, ab);
        xact(1'b1, 1'b1, 18'h00007, 32'h33334444, 0, nst, rdv, ab);
        xact(1'b1, 1'b0, 18'h00007, 32'h0, 0, nst, rdv, ab);
        chk("ws2_rewrite_rd", rdv, 32'h33334444);

        // Reset in the HI half of a read.
        rw = 1'b0; addr = 18'h1F000; en0 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("mid_read_in_hi", {ce0, sa0[0]}, 2'b01);
        reset = 1'b1;
        #1;
        chk("mid_reset_stall", st0, 1'b0);
        @(negedge clock);
        #1;
        chk("mid_reset_stall2", st0, 1'b0);
        chk("mid_reset_strobes", strobes_of(1'b0), 5'h1f);
        chk("mid_reset_bus_z", bz0, 1'b1);
        chk("mid_reset_sram_z", sdz0, 1'b1);
        drive_idle();
        reset = 1'b0;
        bv[0] = 1'b0; bv[1] = 1'b0;
        @(negedge clock);
        idle(1);

`ifdef MC_READ_BUFFER_EN
        xact(1'b0, 1'b1, 18'h00100, 32'h0BADF00D, 0, nst, rdv, ab);
        xact(1'b0, 1'b0, 18'h00100, 32'h0, 0, nst, rdv, ab);
        chk("buf_miss_stall", nst, 3);
        xact(1'b0, 1'b0, 18'h00100, 32'h0, 0, nst, rdv, ab);
        chk("buf_hit_stall", nst, 1);
        chk("buf_hit_value", rdv, 32'h0BADF00D);
        xact(1'b0, 1'b1, 18'h00100, 32'h12345678, 0, nst, rdv, ab);
        xact(1'b0, 1'b0, 18'h00100, 32'h0, 0, nst, rdv, ab);
        chk("buf_upd_stall", nst, 1);
        chk("buf_upd_value", rdv, 32'h12345678);
`endif

        // Fill the address pool on both ports so every later read is defined.
        for (int i = 0; i < 16; i++) begin
            xact(1'b0, 1'b1, {1'b0, pool[i]}, $urandom, 0, nst, rdv, ab);
            xact(1'b1, 1'b1, {1'b1, pool[i]}, $urandom, 0, nst, rdv, ab);
        end

        // Randomized traffic with gaps, back-to-back requests and aborts.
        for (int i = 0; i < 250; i++) begin
            s = 1'($urandom);
            w = 1'($urandom);
            a = {1'($urandom), pool[$urandom_range(15, 0)]};
            d = $urandom;
            xact(s, w, a, d, ($urandom_range(5, 0) == 0) ? -1 : 0, nst, rdv, ab);
            if (ab && w) xact(s, 1'b1, a, $urandom, 0, nst, rdv, ab);
            if ($urandom_range(2, 0) != 0) idle($urandom_range(2, 1));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule
